muldiv_unit: RTL and testbench



---
 rtl/muldiv_pkg.sv | 30 +++
 rtl/muldiv_calc.sv | 63 ++++++
 rtl/muldiv_unit.sv | 96 +++++++++
 tb/tb_muldiv_unit.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// Shared opcode and state encodings for the multiply/divide unit.
// Latency: none (type and helper definitions only).
// Backpressure: none; decode and the unit share these encodings.
package muldiv_pkg;

    typedef enum logic [2:0] {
        MD_MULT  = 3'b000,
        MD_MULTU = 3'b001,
        MD_DIV   = 3'b010,
        MD_DIVU  = 3'b011,
        MD_MTHI  = 3'b100,
        MD_MTLO  = 3'b101,
        MD_RSV6  = 3'b110,
        MD_RSV7  = 3'b111
    } md_op_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } md_state_t;

    function automatic logic is_mul(input md_op_t op);
        return (op == MD_MULT) || (op == MD_MULTU);
    endfunction

    function automatic logic is_div(input md_op_t op);
        return (op == MD_DIV) || (op == MD_DIVU);
    endfunction

endpackage

// File: rtl/muldiv_calc.sv
// Combinational 32x32 multiply and 32/32 divide producing HI/LO result words.
// Latency: purely combinational; the parent holds the result for the busy period.
// Backpressure: none; output follows inputs.
module muldiv_calc
    import muldiv_pkg::*;
(
    input  md_op_t      op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] res_hi,
    output logic [31:0] res_lo,
    output logic        div_zero
);

    logic        signed_op;
    logic [63:0] wide_a;
    logic [63:0] wide_b;
    logic [63:0] prod;
    logic        neg_a;
    logic        neg_b;
    logic [31:0] mag_a;
    logic [31:0] mag_b;
    logic [31:0] dvsr;
    logic [31:0] q_mag;
    logic [31:0] r_mag;
    logic [31:0] quot;
    logic [31:0] rem;

    assign signed_op = (op == MD_MULT) || (op == MD_DIV);

    // Extending to 64 bits first lets one unsigned multiplier serve both
    // signednesses: the low 64 bits of a two's-complement product are exact.
    assign wide_a = signed_op ? {{32{a[31]}}, a} : {32'd0, a};
    assign wide_b = signed_op ? {{32{b[31]}}, b} : {32'd0, b};
    assign prod   = wide_a * wide_b;

    // Divide on magnitudes, then restore signs: quotient truncates toward zero,
    // remainder follows the dividend. 0x80000000 / -1 falls out as 0x80000000.
    assign neg_a = signed_op && a[31];
    assign neg_b = signed_op && b[31];
    assign mag_a = neg_a ? (32'd0 - a) : a;
    assign mag_b = neg_b ? (32'd0 - b) : b;
    // A zero divisor is swapped for 1 so the divider never sees zero; the
    // result is discarded via div_zero anyway.
    assign dvsr  = (b == 32'd0) ? 32'd1 : mag_b;
    assign q_mag = mag_a / dvsr;
    assign r_mag = mag_a % dvsr;
    assign quot  = (neg_a ^ neg_b) ? (32'd0 - q_mag) : q_mag;
    assign rem   = neg_a ? (32'd0 - r_mag) : r_mag;

    // Select the HI/LO pair for the requested operation.
    always_comb begin
        res_hi = prod[63:32];
        res_lo = prod[31:0];
        if (is_div(op)) begin
            res_hi = rem;
            res_lo = quot;
        end
    end

    assign div_zero = is_div(op) && (b == 32'd0);

endmodule

// File: rtl/muldiv_unit.sv
// Multi-cycle MULT/DIV unit with architectural HI/LO and MTHI/MTLO writes.
// Latency: mult/div commit after MULT_CYCLES/DIV_CYCLES edges; MTHI/MTLO after 1 edge.
// Backpressure: busy is high while an operation runs; start during busy is ignored.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  md_op,
    input  logic [31:0] src_a,
    input  logic [31:0] src_b,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W   = $clog2(MAX_CYC + 1);

    md_op_t      op;
    md_state_t   state;
    logic [CNT_W-1:0] cnt;
    logic [31:0] pend_hi;
    logic [31:0] pend_lo;
    logic        pend_wr;
    logic [31:0] res_hi;
    logic [31:0] res_lo;
    logic        div_zero;

    assign op = md_op_t'(md_op);

    muldiv_calc u_calc (
        .op       (op),
        .a        (src_a),
        .b        (src_b),
        .res_hi   (res_hi),
        .res_lo   (res_lo),
        .div_zero (div_zero)
    );

    // Issue/run state machine: result is computed at issue and held in the
    // pending registers; HI/LO only change at the final edge of the busy period.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= ST_IDLE;
            busy    <= 1'b0;
            cnt     <= '0;
            pend_hi <= 32'd0;
            pend_lo <= 32'd0;
            pend_wr <= 1'b0;
            hi      <= 32'd0;
            lo      <= 32'd0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        if (is_mul(op) || is_div(op)) begin
                            pend_hi <= res_hi;
                            pend_lo <= res_lo;
                            pend_wr <= !div_zero;
                            cnt     <= is_div(op) ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
                            state   <= ST_RUN;
                            busy    <= 1'b1;
                        end else if (op == MD_MTHI) begin
                            hi <= src_a;
                        end else if (op == MD_MTLO) begin
                            lo <= src_a;
                        end
                    end
                end
                ST_RUN: begin
                    if (cnt == CNT_W'(1)) begin
                        if (pend_wr) begin
                            hi <= pend_hi;
                            lo <= pend_lo;
                        end
                        cnt   <= '0;
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed vector table, corner sequences, random vs model.
// Latency: checks exact busy length and commit timing for every multi-cycle op.
// Backpressure: checks that start during busy is ignored.
module tb_muldiv_unit;
    import muldiv_pkg::*;

    localparam int MC = 5;
    localparam int DC = 10;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [2:0]  md_op;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;

    int tests = 0;
    int fails = 0;

    // Reference HI/LO state for the random phase.
    logic [31:0] m_hi;
    logic [31:0] m_lo;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] e_hi;
        logic [31:0] e_lo;
        int          cyc;
        string       name;
    } vec_t;

    vec_t vecs[9];

    always #5 clk = ~clk;

    muldiv_unit #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .md_op (md_op),
        .src_a (src_a),
        .src_b (src_b),
        .busy  (busy),
        .hi    (hi),
        .lo    (lo)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Issue a mult/div, scramble operands afterwards, count busy cycles and
    // verify HI/LO hold until commit, then check the committed values.
    task automatic run_op(input string name, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input int exp_cyc,
                          input logic [31:0] e_hi, input logic [31:0] e_lo);
        logic [31:0] old_hi;
        logic [31:0] old_lo;
        int          cyc;
        logic        held;
        old_hi = hi;
        old_lo = lo;
        start = 1'b1; md_op = op; src_a = a; src_b = b;
        tick();
        start = 1'b0; src_a = $urandom; src_b = $urandom;
        cyc  = 0;
        held = 1'b1;
        while (busy === 1'b1 && cyc < 100) begin
            if (hi !== old_hi || lo !== old_lo) held = 1'b0;
            cyc++;
            tick();
        end
        check({name, " busy_cycles"}, 32'(cyc), 32'(exp_cyc));
        check({name, " hold"}, {31'd0, held}, 32'd1);
        check({name, " hi"}, hi, e_hi);
        check({name, " lo"}, lo, e_lo);
    endtask

    // Single-cycle op (MTHI/MTLO/reserved): busy must stay low, values next cycle.
    task automatic quick_op(input string name, input logic [2:0] op, input logic [31:0] a,
                            input logic [31:0] e_hi, input logic [31:0] e_lo);
        start = 1'b1; md_op = op; src_a = a; src_b = $urandom;
        tick();
        start = 1'b0;
        check({name, " busy"}, {31'd0, busy}, 32'd0);
        check({name, " hi"}, hi, e_hi);
        check({name, " lo"}, lo, e_lo);
    endtask

    // Architectural reference: plain 64-bit arithmetic on the operand values.
    task automatic model_step(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                              output int cyc);
        longint          sa, sb, sp, q, r;
        longint unsigned up;
        cyc = 0;
        case (op)
            3'd0: begin
                sa = longint'($signed(a)); sb = longint'($signed(b));
                sp = sa * sb;
                m_hi = sp[63:32]; m_lo = sp[31:0];
                cyc = MC;
            end
            3'd1: begin
                up = {32'd0, a} * {32'd0, b};
                m_hi = up[63:32]; m_lo = up[31:0];
                cyc = MC;
            end
            3'd2: begin
                if (b != 32'd0) begin
                    sa = longint'($signed(a)); sb = longint'($signed(b));
                    q = sa / sb; r = sa % sb;
                    m_hi = r[31:0]; m_lo = q[31:0];
                end
                cyc = DC;
            end
            3'd3: begin
                if (b != 32'd0) begin
                    m_hi = a % b; m_lo = a / b;
                end
                cyc = DC;
            end
            3'd4: m_hi = a;
            3'd5: m_lo = a;
            default: ;
        endcase
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        int          cyc;
        logic        quiet;
        logic [2:0]  r_op;
        logic [31:0] r_a;
        logic [31:0] r_b;

        vecs[0] = '{MD_MULT,  32'hFFFFFFFE, 32'd3,        32'hFFFFFFFF, 32'hFFFFFFFA, MC, "mult_neg"};
        vecs[1] = '{MD_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, MC, "multu_max"};
        vecs[2] = '{MD_DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, DC, "div_neg"};
        vecs[3] = '{MD_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, DC, "div_ovf"};
        vecs[4] = '{MD_DIVU,  32'd7,        32'd2,        32'h00000001, 32'h00000003, DC, "divu_small"};
        vecs[5] = '{MD_DIV,   32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, DC, "div_negb"};
        vecs[6] = '{MD_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, MC, "mult_min"};
        vecs[7] = '{MD_MULTU, 32'h80000000, 32'd2,        32'h00000001, 32'h00000000, MC, "multu_carry"};
        vecs[8] = '{MD_DIVU,  32'hFFFFFFFF, 32'd10,       32'h00000005, 32'h19999999, DC, "divu_big"};

        reset = 1'b1; start = 1'b0; md_op = 3'd0; src_a = 32'd0; src_b = 32'd0;
        tick(); tick();
        reset = 1'b0;
        check("reset busy", {31'd0, busy}, 32'd0);
        check("reset hi", hi, 32'd0);
        check("reset lo", lo, 32'd0);

        // Directed vectors, issued back-to-back in the first idle cycle.
        for (int i = 0; i < 9; i++) begin
            run_op(vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].cyc,
                   vecs[i].e_hi, vecs[i].e_lo);
        end

        // MTHI/MTLO set up known values, then divide by zero must leave them.
        quick_op("mthi", MD_MTHI, 32'h11, 32'h11, vecs[8].e_lo);
        quick_op("mtlo", MD_MTLO, 32'h22, 32'h11, 32'h22);
        run_op("divu_zero", MD_DIVU, 32'd7, 32'd0, DC, 32'h11, 32'h22);
        run_op("div_zero", MD_DIV, 32'hFFFFFFF0, 32'd0, DC, 32'h11, 32'h22);
        quick_op("reserved", MD_RSV6, 32'hFFFF, 32'h11, 32'h22);
        quick_op("mtlo_1234", MD_MTLO, 32'h1234, 32'h11, 32'h1234);

        // MTHI issued during a busy MULT must be dropped.
        start = 1'b1; md_op = MD_MULT; src_a = 32'hFFFFFFFE; src_b = 32'd3;
        tick();
        start = 1'b0;
        cyc = 0;
        while (busy === 1'b1 && cyc < 100) begin
            if (cyc == 2) begin
                start = 1'b1; md_op = MD_MTHI; src_a = 32'hDEAD;
            end else begin
                start = 1'b0;
            end
            if (cyc == 3) check("mthi_in_run hi", hi, 32'h11);
            cyc++;
            tick();
        end
        start = 1'b0;
        check("mthi_in_run busy_cycles", 32'(cyc), 32'(MC));
        check("mthi_in_run hi", hi, 32'hFFFFFFFF);
        check("mthi_in_run lo", lo, 32'hFFFFFFFA);

        // Reset on the fourth busy cycle of a DIV abandons it.
        start = 1'b1; md_op = MD_DIV; src_a = 32'd100; src_b = 32'd7;
        tick();
        start = 1'b0;
        tick(); tick(); tick();
        check("pre_reset busy", {31'd0, busy}, 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("mid_reset busy", {31'd0, busy}, 32'd0);
        check("mid_reset hi", hi, 32'd0);
        check("mid_reset lo", lo, 32'd0);
        quiet = 1'b1;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) quiet = 1'b0;
        end
        check("mid_reset no_commit", {31'd0, quiet}, 32'd1);

        // Random ops against the reference model.
        m_hi = 32'd0;
        m_lo = 32'd0;
        for (int i = 0; i < 40; i++) begin
            r_op = 3'($urandom_range(0, 7));
            r_a  = $urandom;
            r_b  = $urandom;
            if ($urandom_range(0, 3) == 0) r_b = 32'($urandom_range(0, 15));
            if ($urandom_range(0, 9) == 0) r_b = 32'd0;
            model_step(r_op, r_a, r_b, cyc);
            if (cyc > 0)
                run_op($sformatf("rand%0d op%0d", i, r_op), r_op, r_a, r_b, cyc, m_hi, m_lo);
            else
                quick_op($sformatf("rand%0d op%0d", i, r_op), r_op, r_a, m_hi, m_lo);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
